ex_muldiv: RTL and testbench

//   Iterative RV32M multiply/divide unit inside the EX stage, fed by the ID/EX pipeline register
//   (alusel/aluop/op1/op2). One bit per cycle: shift-add for multiply, restoring division for divide.

---
 rtl/ex_muldiv_pkg.sv | 44 ++++
 rtl/ex_muldiv_sign_fix.sv | 19 +
 rtl/ex_muldiv.sv | 208 ++++++++++++++++++++
 tb/tb_ex_muldiv.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg
//   Shared types and helpers for the iterative RV32M multiply/divide unit.
//   - MD_XLEN       default operand/result width
//   - md_state_e    FSM states (IDLE, BUSY, DONE)
//   - md_funct_e    RV32M funct3 encodings
//   - md_is_div / md_op1_signed / md_op2_signed  decode helpers on funct3
package ex_muldiv_pkg;

  localparam int MD_XLEN = 32;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_funct_e;

  // Divide/remainder ops all have funct3[2] set.
  function automatic logic md_is_div(input logic [2:0] funct);
    return funct[2];
  endfunction

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
  function automatic logic md_op1_signed(input logic [2:0] funct);
    return (funct == MD_MULH) || (funct == MD_MULHSU) ||
           (funct == MD_DIV)  || (funct == MD_REM);
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM.
  function automatic logic md_op2_signed(input logic [2:0] funct);
    return (funct == MD_MULH) || (funct == MD_DIV) || (funct == MD_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_sign_fix.sv
// ex_muldiv_sign_fix
//   Combinational conditional two's-complement negate at full width W.
//   Used to take magnitudes of signed operands and to re-apply the sign
//   to the final product / quotient / remainder.
//   Ports:
//     value_i  in  W  value to process
//     neg_i    in  1  1 = negate, 0 = pass through
//     value_o  out W  result
module ex_muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] value_i,
  input  logic         neg_i,
  output logic [W-1:0] value_o
);

  assign value_o = neg_i ? (~value_i + W'(1)) : value_i;

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv
//   Iterative RV32M multiply/divide unit for the EX stage. One bit per cycle:
//   shift-add multiply on magnitudes, restoring divide on magnitudes, with the
//   sign applied once at the end. Requests a pipeline stall while an op is in
//   flight and presents the result in DONE until EX consumes it.
//   Ports:
//     clock       in   1     system clock
//     reset       in   1     synchronous, active-high
//     start_i     in   1     valid M-extension op held in EX (level)
//     funct_i     in   3     RV32M funct3
//     op1_i       in   XLEN  rs1 value
//     op2_i       in   XLEN  rs2 value
//     ack_i       in   1     EX advances this cycle; consumes a DONE result
//     result_o    out  XLEN  result, valid while done_o
//     done_o      out  1     result available
//     stallreq_o  out  1     stall request: start_i && state != DONE
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN = MD_XLEN
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start_i,
  input  logic [2:0]      funct_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic            ack_i,
  output logic [XLEN-1:0] result_o,
  output logic            done_o,
  output logic            stallreq_o
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e        state_reg, state_next;
  logic [CNT_W-1:0] counter_reg, counter_next;
  // acc: product high half / partial remainder.
  // low: multiplier shifting out, product low half / dividend shifting out, quotient shifting in.
  logic [XLEN-1:0]  acc_reg, acc_next;
  logic [XLEN-1:0]  low_reg, low_next;
  logic [XLEN-1:0]  b_reg, b_next;          // multiplicand / divisor magnitude
  logic [2:0]       funct_reg, funct_next;
  logic             neg_res_reg, neg_res_next;  // product / quotient sign
  logic             neg_rem_reg, neg_rem_next;  // remainder sign (dividend sign)
  logic [XLEN-1:0]  result_reg, result_next;

  // ---- operand magnitudes --------------------------------------------------
  logic [XLEN-1:0] opnd     [2];
  logic            opnd_neg [2];
  logic [XLEN-1:0] opnd_mag [2];

  assign opnd[0]     = op1_i;
  assign opnd[1]     = op2_i;
  assign opnd_neg[0] = md_op1_signed(funct_i) & op1_i[XLEN-1];
  assign opnd_neg[1] = md_op2_signed(funct_i) & op2_i[XLEN-1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_mag
      ex_muldiv_sign_fix #(.W(XLEN)) u_mag (
        .value_i (opnd[gi]),
        .neg_i   (opnd_neg[gi]),
        .value_o (opnd_mag[gi])
      );
    end
  endgenerate

  logic div_by_zero, div_overflow;
  assign div_by_zero  = md_is_div(funct_i) && (op2_i == '0);
  assign div_overflow = md_is_div(funct_i) && md_op1_signed(funct_i) &&
                        (op1_i == MOST_NEG) && (op2_i == '1);

  // ---- one iteration step --------------------------------------------------
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   rem_shift, rem_diff;
  logic [XLEN-1:0] step_acc, step_low;

  assign mul_sum   = {1'b0, acc_reg} + (low_reg[0] ? {1'b0, b_reg} : '0);
  assign rem_shift = {acc_reg, low_reg[XLEN-1]};
  assign rem_diff  = rem_shift - {1'b0, b_reg};

  always_comb begin
    step_acc = acc_reg;
    step_low = low_reg;
    if (md_is_div(funct_reg)) begin
      // Borrow out (msb set) means the trial subtraction failed: restore.
      if (!rem_diff[XLEN]) begin
        step_acc = rem_diff[XLEN-1:0];
        step_low = {low_reg[XLEN-2:0], 1'b1};
      end else begin
        step_acc = rem_shift[XLEN-1:0];
        step_low = {low_reg[XLEN-2:0], 1'b0};
      end
    end else begin
      // Shift the carry-extended sum right; the consumed multiplier bit drops out.
      step_acc = mul_sum[XLEN:1];
      step_low = {mul_sum[0], low_reg[XLEN-1:1]};
    end
  end

  // ---- sign correction on the final step's values -------------------------
  logic [2*XLEN-1:0] prod_fixed;
  logic [XLEN-1:0]   quo_fixed, rem_fixed, final_result;

  ex_muldiv_sign_fix #(.W(2*XLEN)) u_fix_prod (
    .value_i ({step_acc, step_low}), .neg_i (neg_res_reg), .value_o (prod_fixed));
  ex_muldiv_sign_fix #(.W(XLEN)) u_fix_quo (
    .value_i (step_low), .neg_i (neg_res_reg), .value_o (quo_fixed));
  ex_muldiv_sign_fix #(.W(XLEN)) u_fix_rem (
    .value_i (step_acc), .neg_i (neg_rem_reg), .value_o (rem_fixed));

  always_comb begin
    final_result = prod_fixed[2*XLEN-1:XLEN];
    if (md_is_div(funct_reg))
      final_result = funct_reg[1] ? rem_fixed : quo_fixed;
    else if (funct_reg == MD_MUL)
      final_result = prod_fixed[XLEN-1:0];
  end

  // ---- next-state / datapath control --------------------------------------
  always_comb begin
    state_next   = state_reg;
    counter_next = counter_reg;
    acc_next     = acc_reg;
    low_next     = low_reg;
    b_next       = b_reg;
    funct_next   = funct_reg;
    neg_res_next = neg_res_reg;
    neg_rem_next = neg_rem_reg;
    result_next  = result_reg;

    case (state_reg)
      MD_IDLE: begin
        if (start_i) begin
          funct_next   = funct_i;
          counter_next = '0;
          acc_next     = '0;
          low_next     = opnd_mag[0];
          b_next       = opnd_mag[1];
          neg_res_next = opnd_neg[0] ^ opnd_neg[1];
          neg_rem_next = opnd_neg[0];
          if (div_by_zero) begin
            result_next = funct_i[1] ? op1_i : '1;
            state_next  = MD_DONE;
          end else if (div_overflow) begin
            result_next = funct_i[1] ? '0 : MOST_NEG;
            state_next  = MD_DONE;
          end else begin
            state_next = MD_BUSY;
          end
        end
      end

      MD_BUSY: begin
        if (!start_i) begin
          // Op left EX (bubble/flush): drop the partial result.
          state_next = MD_IDLE;
        end else begin
          acc_next     = step_acc;
          low_next     = step_low;
          counter_next = counter_reg + 1'b1;
          if (counter_reg == CNT_W'(XLEN-1)) begin
            result_next = final_result;
            state_next  = MD_DONE;
          end
        end
      end

      MD_DONE: begin
        // Always pass through IDLE so a restart sees the next ID/EX contents.
        if (ack_i)
          state_next = MD_IDLE;
      end

      default: state_next = MD_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= MD_IDLE;
      counter_reg <= '0;
      acc_reg     <= '0;
      low_reg     <= '0;
      b_reg       <= '0;
      funct_reg   <= '0;
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      result_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      counter_reg <= counter_next;
      acc_reg     <= acc_next;
      low_reg     <= low_next;
      b_reg       <= b_next;
      funct_reg   <= funct_next;
      neg_res_reg <= neg_res_next;
      neg_rem_reg <= neg_rem_next;
      result_reg  <= result_next;
    end
  end

  assign result_o   = result_reg;
  assign done_o     = (state_reg == MD_DONE);
  assign stallreq_o = start_i && (state_reg != MD_DONE);

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv
//   Self-checking bench for ex_muldiv: directed cases plus randomized ops,
//   each compared against an arithmetic reference of the RV32M rules.
module tb_ex_muldiv;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_i;
  logic [2:0]  funct_i;
  logic [31:0] op1_i, op2_i;
  logic        ack_i;
  logic [31:0] result_o;
  logic        done_o;
  logic        stallreq_o;

  int n_checks = 0;
  int n_errors = 0;

  ex_muldiv dut (
    .clock      (clock),
    .reset      (reset),
    .start_i    (start_i),
    .funct_i    (funct_i),
    .op1_i      (op1_i),
    .op2_i      (op2_i),
    .ack_i      (ack_i),
    .result_o   (result_o),
    .done_o     (done_o),
    .stallreq_o (stallreq_o)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // RV32M reference using plain integer arithmetic.
  function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    int          ia, ib;
    longint      sp;
    logic [63:0] up, ua, ub;
    logic        ovf;
    ia  = a;
    ib  = b;
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin up = ua * ub; return up[31:0]; end
      3'd1: begin sp = longint'(ia) * longint'(ib); up = sp; return up[63:32]; end
      3'd2: begin sp = longint'(ia) * longint'(ub); up = sp; return up[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Start an op, wait for done, check result/latency/stall, hold for
  // `hold` stalled cycles, then ack with start still high.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    logic [31:0] exp;
    int          lat, cyc;
    exp = ref_md(f, a, b);
    lat = ref_latency(f, a, b);
    start_i = 1'b1; funct_i = f; op1_i = a; op2_i = b; ack_i = 1'b0;
    #1;
    check_eq({tag, ".stall0"}, 32'(stallreq_o), 32'd1);
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clock); #1;
      cyc++;
      if (done_o) break;
      check_eq({tag, ".stall_busy"}, 32'(stallreq_o), 32'd1);
    end
    check_eq({tag, ".latency"}, cyc, lat);
    check_eq({tag, ".result"}, result_o, exp);
    check_eq({tag, ".stall_done"}, 32'(stallreq_o), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      check_eq({tag, ".hold_done"}, 32'(done_o), 32'd1);
      check_eq({tag, ".hold_result"}, result_o, exp);
      check_eq({tag, ".hold_stall"}, 32'(stallreq_o), 32'd0);
    end
    ack_i = 1'b1;
    @(posedge clock); #1;
    check_eq({tag, ".ack_done"}, 32'(done_o), 32'd0);
    start_i = 1'b0; ack_i = 1'b0;
    @(posedge clock); #1;
    check_eq({tag, ".idle_done"}, 32'(done_o), 32'd0);
    $display("op %s f=%0d a=%h b=%h -> %h (exp %h) lat=%0d", tag, f, a, b, result_o, exp, cyc);
  endtask

  logic [31:0] pool [6];

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rf;
    pool[0] = 32'h0; pool[1] = 32'h8000_0000; pool[2] = 32'hFFFF_FFFF;
    pool[3] = 32'h1; pool[4] = 32'h7FFF_FFFF; pool[5] = 32'h7;

    reset = 1'b1; start_i = 1'b0; funct_i = 3'd0; op1_i = '0; op2_i = '0; ack_i = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("reset.result", result_o, 32'h0);
    check_eq("reset.done", 32'(done_o), 32'd0);
    check_eq("reset.stall", 32'(stallreq_o), 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    run_op("mul",    3'd0, 32'd7, 32'hFFFF_FFFD, 0);
    run_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 0);
    run_op("mulhu",  3'd3, 32'h8000_0000, 32'h8000_0000, 0);
    run_op("mulhsu", 3'd2, 32'h8000_0000, 32'h8000_0000, 0);
    run_op("divu",   3'd5, 32'd100, 32'd7, 0);
    run_op("remu",   3'd7, 32'd100, 32'd7, 0);
    run_op("div",    3'd4, 32'hFFFF_FF9C, 32'd7, 0);
    run_op("rem",    3'd6, 32'hFFFF_FF9C, 32'd7, 0);
    run_op("div0",   3'd4, 32'd5, 32'd0, 0);
    run_op("rem0",   3'd6, 32'd5, 32'd0, 0);
    run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("hold",   3'd1, 32'hDEAD_BEEF, 32'h1234_5678, 5);

    // Abort: start drops at BUSY cycle 10.
    start_i = 1'b1; funct_i = 3'd5; op1_i = 32'd1000; op2_i = 32'd3;
    repeat (11) @(posedge clock);
    #1;
    start_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      check_eq("abort.done", 32'(done_o), 32'd0);
    end
    $display("op abort done=%b", done_o);
    run_op("after_abort", 3'd5, 32'd1000, 32'd3, 0);

    // Reset mid-BUSY clears all outputs.
    start_i = 1'b1; funct_i = 3'd1; op1_i = 32'h1234_5678; op2_i = 32'h9ABC_DEF0;
    repeat (15) @(posedge clock);
    #1;
    reset = 1'b1; start_i = 1'b0;
    @(posedge clock); #1;
    check_eq("rst_busy.result", result_o, 32'h0);
    check_eq("rst_busy.done", 32'(done_o), 32'd0);
    check_eq("rst_busy.stall", 32'(stallreq_o), 32'd0);
    $display("op reset_mid_busy result=%h done=%b", result_o, done_o);
    reset = 1'b0;
    @(posedge clock); #1;

    // Randomized ops, operands sometimes drawn from corner values.
    for (int n = 0; n < 150; n++) begin
      rf = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
      run_op("rand", rf, ra, rb, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
